guess_entry_ctrl: RTL and testbench
===================================

Name: guess_entry_ctrl

Overview:
- Sequences player keypad input into a complete Bulls-and-Cows guess.
- Detects key presses, encodes the digit, and assembles NUM_DIGITS distinct BCD digits, most significant first.
- Handles delete and enter keys.
- Offers the finished guess to the scoring logic over a valid/ready handshake.
- Sits between the debounced keypad and the bulls/cows comparator.

Parameters:
- NUM_DIGITS, 4, digits per guess (2..8).
- DIGIT_W, 4, bits per BCD digit (fixed at 4).

Ports:
- CLK, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- key, input, 10, digit keys; bit i high while key i is held. Debounced and synchronised upstream.
- del, input, 1, delete key level.
- enter, input, 1, enter key level.
- guess_ready, input, 1, scorer accepts the guess.
- guess, output, NUM_DIGITS*DIGIT_W, entered digits; digit 0 in the top nibble.
- digit_count, output, 4, number of digits entered (0..NUM_DIGITS).
- guess_valid, output, 1, guess complete and offered to the scorer.
- dup_err, output, 1, one-cycle pulse: duplicate digit rejected.
- busy, output, 1, high in SUBMIT.

Behaviour:

Reset:
- Takes effect immediately on rst.
- guess = 0, digit_count = 0, guess_valid = 0, dup_err = 0, busy = 0, state = ENTRY.
- Press-history flag any_q = 1, so a key held through reset release is not accepted.

Press detection:
- any = |key | del | enter.
- A press event occurs on a cycle where any = 1 and any_q = 0. any_q <= any every cycle.
- Holding keys generates no further events; all keys must be released before the next press.
- Digit value = lowest asserted key index (key[0] has highest priority).
- Within one event, priority is del > enter > digit.
- All updates land on the rising edge at which the event is sampled (one-edge latency).

ENTRY state:
- Digit event, value already present among the first digit_count slots: no storage change; dup_err = 1 for one cycle.
- Digit event, otherwise: write the value to slot digit_count and increment digit_count.
  - If the new count = NUM_DIGITS, go to FULL.
- del event: if digit_count > 0, decrement it and clear that slot to 0. If digit_count = 0, ignore.
- enter event: ignored; the guess is incomplete.

FULL state:
- Digit event: ignored, no dup_err.
- del event: clear the last slot, digit_count = NUM_DIGITS-1, go to ENTRY.
- enter event: go to SUBMIT.

SUBMIT state:
- guess_valid = 1 and busy = 1.
- guess is held stable until the handshake completes.
- All key events are ignored; any_q still tracks.
- On a cycle with guess_valid & guess_ready: clear guess and digit_count to 0 and go to ENTRY on the same edge. guess_valid is 0 from the next cycle.
- guess_ready without guess_valid has no effect.

Outputs and state encoding:
- guess_valid and busy are registered outputs.
- Unused or illegal state encodings recover to ENTRY with the slots cleared.

Decomposition:
- Shared package gm_pkg holds:
  - state enum {ENTRY, FULL, SUBMIT};
  - NUM_DIGITS and DIGIT_W defaults;
  - KEY_W = 10;
  - a function to_bcd(key) returning the lowest asserted index.
- Sub-module key_press_detect holds the any_q register and the priority logic. Its outputs are evt_digit, evt_del, evt_enter (single-cycle pulses) and digit[3:0].
- Duplicate check is a combinational compare of the new digit against the filled slots, qualified by digit_count.

Test Plan:
1. Reset with key[5] held, then release rst. No event until key[5] drops and rises again; then guess = 0x5000 and digit_count = 1.
2. Press 1, 2, 3, 4 then enter, with guess_ready = 0 for 5 cycles, then 1.
   - guess = 0x1234 and guess_valid = 1 stable for 5 cycles.
   - Accepted on the ready cycle; next cycle guess = 0, digit_count = 0, guess_valid = 0.
3. Press 7, 7. The second press pulses dup_err for exactly 1 cycle; guess = 0x7000 and digit_count = 1 are unchanged.
4. Press 9, 8, del, 6. Result guess = 0x9600, digit_count = 2. Press del ×3: digit_count = 0 and a further del is ignored.
5. Press key[3] and key[8] together, then del+enter together.
   - First event stores 3.
   - Second event performs a delete only and stays in ENTRY.
6. Enter 5, 6, 7, 8 then enter, with rst asserted mid-SUBMIT. guess_valid falls immediately (asynchronously), all outputs are 0, and state = ENTRY.

Source files
------------

// File: rtl/gm_pkg.sv
// gm_pkg: shared types, sizes and key encoding for the guess entry path
package gm_pkg;
  typedef enum logic [1:0] {ENTRY, FULL, SUBMIT} state_t;
  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_DIGIT_W = 4;
  localparam int KEY_W = 10;
  function automatic logic [3:0] to_bcd(input logic [KEY_W-1:0] k);
    to_bcd = '0;
    for (int i = KEY_W - 1; i >= 0; i--) if (k[i]) to_bcd = 4'(i);
  endfunction
endpackage

// File: rtl/guess_entry_ctrl_if.sv
// guess_entry_ctrl_if: keypad inputs and scorer handshake of the guess entry block
interface guess_entry_ctrl_if #(parameter int NUM_DIGITS = gm_pkg::DEF_NUM_DIGITS, parameter int DIGIT_W = gm_pkg::DEF_DIGIT_W);
  import gm_pkg::*;
  logic [KEY_W-1:0] key;
  logic del;
  logic enter;
  logic guess_ready;
  logic [NUM_DIGITS*DIGIT_W-1:0] guess;
  logic [3:0] digit_count;
  logic guess_valid;
  logic dup_err;
  logic busy;
  modport master(output key, del, enter, guess_ready, input guess, digit_count, guess_valid, dup_err, busy);
  modport slave(input key, del, enter, guess_ready, output guess, digit_count, guess_valid, dup_err, busy);
endinterface

// File: rtl/guess_entry_ctrl_key_press_detect.sv
// key_press_detect: turns keypad levels into single-cycle prioritised press events
module key_press_detect
  import gm_pkg::*;
(
  input  logic             CLK,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  input  logic             del,
  input  logic             enter,
  output logic             evt_digit,
  output logic             evt_del,
  output logic             evt_enter,
  output logic [3:0]       digit
);
  logic any, any_d, any_q, press;
  // an event needs every key released first; priority del > enter > digit
  always_comb begin
    any = |key | del | enter;
    any_d = any;
    press = any & ~any_q;
    evt_del = press & del;
    evt_enter = press & ~del & enter;
    evt_digit = press & ~del & ~enter & |key;
    digit = to_bcd(key);
  end
  // history starts high so a key held through reset is never taken as a press
  always_ff @(posedge CLK or posedge rst)
    if (rst) any_q <= 1'b1;
    else any_q <= any_d;
endmodule

// File: rtl/guess_entry_ctrl.sv
// guess_entry_ctrl: assembles distinct keypad digits into a guess and offers it to the scorer
module guess_entry_ctrl
  import gm_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input logic CLK,
  input logic rst,
  guess_entry_ctrl_if.slave bus
);
  localparam int GW = NUM_DIGITS * DIGIT_W;
  localparam logic [3:0] LAST = 4'(NUM_DIGITS - 1);
  state_t state_d, state_q;
  logic [GW-1:0] guess_d, guess_q;
  logic [3:0] cnt_d, cnt_q, wr_idx, digit;
  logic [DIGIT_W-1:0] wr_val;
  logic valid_d, valid_q, busy_d, busy_q, dup_d, dup_q;
  logic evt_digit, evt_del, evt_enter, dup, wr, clr;
  key_press_detect u_kpd (
    .CLK(CLK), .rst(rst), .key(bus.key), .del(bus.del), .enter(bus.enter),
    .evt_digit(evt_digit), .evt_del(evt_del), .evt_enter(evt_enter), .digit(digit)
  );
  // duplicate when the new digit matches any slot already filled
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (4'(i) < cnt_q && guess_q[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] == DIGIT_W'(digit)) dup = 1'b1;
  end
  // next state, slot writes and registered outputs; handshake clears on the accepting edge
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dup_d = 1'b0;
    wr = 1'b0;
    wr_idx = cnt_q;
    wr_val = DIGIT_W'(digit);
    clr = 1'b0;
    case (state_q)
      ENTRY:
        if (evt_del && cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          wr = 1'b1;
          wr_idx = cnt_q - 4'd1;
          wr_val = '0;
        end else if (evt_digit && dup) dup_d = 1'b1;
        else if (evt_digit) begin
          wr = 1'b1;
          cnt_d = cnt_q + 4'd1;
          state_d = (cnt_q == LAST) ? FULL : ENTRY;
        end
      FULL:
        if (evt_del) begin
          cnt_d = LAST;
          wr = 1'b1;
          wr_idx = LAST;
          wr_val = '0;
          state_d = ENTRY;
        end else if (evt_enter) state_d = SUBMIT;
      SUBMIT:
        if (valid_q && bus.guess_ready) begin
          clr = 1'b1;
          cnt_d = '0;
          state_d = ENTRY;
        end
      default: begin
        clr = 1'b1;
        cnt_d = '0;
        state_d = ENTRY;
      end
    endcase
    guess_d = clr ? '0 : guess_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (wr && 4'(i) == wr_idx) guess_d[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = wr_val;
    valid_d = state_d == SUBMIT;
    busy_d = state_d == SUBMIT;
  end
  // state and output registers
  always_ff @(posedge CLK or posedge rst)
    if (rst) begin
      state_q <= ENTRY;
      guess_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      dup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      guess_q <= guess_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      dup_q <= dup_d;
    end
  assign bus.guess = guess_q;
  assign bus.digit_count = cnt_q;
  assign bus.guess_valid = valid_q;
  assign bus.busy = busy_q;
  assign bus.dup_err = dup_q;
endmodule

// File: tb/tb_guess_entry_ctrl.sv
// tb_guess_entry_ctrl: directed vectors with hand-computed expectations
module tb_guess_entry_ctrl;
  logic CLK = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  guess_entry_ctrl_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus ();
  guess_entry_ctrl #(.NUM_DIGITS(4), .DIGIT_W(4)) dut (.CLK(CLK), .rst(rst), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic press(input logic [9:0] k, input logic d, input logic e);
    @(negedge CLK);
    bus.key = k;
    bus.del = d;
    bus.enter = e;
    @(negedge CLK);
    bus.key = '0;
    bus.del = 1'b0;
    bus.enter = 1'b0;
  endtask
  task automatic dig(input int v);
    press(10'(1 << v), 1'b0, 1'b0);
  endtask
  task automatic chk_state(input string tag, input logic [15:0] g, input logic [3:0] c, input logic v);
    chk({tag, ".guess"}, 32'(bus.guess), 32'(g));
    chk({tag, ".count"}, 32'(bus.digit_count), 32'(c));
    chk({tag, ".valid"}, 32'(bus.guess_valid), 32'(v));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(v));
  endtask
  initial begin
    bus.key = 10'h020;
    bus.del = 1'b0;
    bus.enter = 1'b0;
    bus.guess_ready = 1'b0;
    repeat (3) @(negedge CLK);
    chk_state("rst", 16'h0000, 4'd0, 1'b0);
    chk("rst.dup", 32'(bus.dup_err), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge CLK);
    chk_state("held", 16'h0000, 4'd0, 1'b0);
    bus.key = '0;
    dig(5);
    chk_state("t1", 16'h5000, 4'd1, 1'b0);
    press('0, 1'b1, 1'b0);
    chk_state("t1.del", 16'h0000, 4'd0, 1'b0);
    dig(1); dig(2); dig(3); dig(4);
    chk_state("t2.full", 16'h1234, 4'd4, 1'b0);
    press('0, 1'b0, 1'b1);
    chk_state("t2.sub", 16'h1234, 4'd4, 1'b1);
    dig(9);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk_state("t2.hold", 16'h1234, 4'd4, 1'b1);
    end
    bus.guess_ready = 1'b1;
    @(negedge CLK);
    bus.guess_ready = 1'b0;
    chk_state("t2.acc", 16'h0000, 4'd0, 1'b0);
    dig(7);
    dig(7);
    chk("t3.dup", 32'(bus.dup_err), 32'd1);
    chk_state("t3", 16'h7000, 4'd1, 1'b0);
    @(negedge CLK);
    chk("t3.dup_off", 32'(bus.dup_err), 32'd0);
    press('0, 1'b1, 1'b0);
    dig(9); dig(8);
    press('0, 1'b1, 1'b0);
    dig(6);
    chk_state("t4", 16'h9600, 4'd2, 1'b0);
    press('0, 1'b1, 1'b0);
    press('0, 1'b1, 1'b0);
    press('0, 1'b1, 1'b0);
    chk_state("t4.empty", 16'h0000, 4'd0, 1'b0);
    press('0, 1'b0, 1'b1);
    chk_state("t4.enter", 16'h0000, 4'd0, 1'b0);
    press(10'h108, 1'b0, 1'b0);
    chk_state("t5.prio", 16'h3000, 4'd1, 1'b0);
    press('0, 1'b1, 1'b1);
    chk_state("t5.delent", 16'h0000, 4'd0, 1'b0);
    dig(5); dig(6); dig(7); dig(8);
    dig(9);
    chk_state("t6.fullign", 16'h5678, 4'd4, 1'b0);
    chk("t6.nodup", 32'(bus.dup_err), 32'd0);
    press('0, 1'b1, 1'b0);
    chk_state("t6.fulldel", 16'h5670, 4'd3, 1'b0);
    dig(8);
    press('0, 1'b0, 1'b1);
    chk_state("t6.sub", 16'h5678, 4'd4, 1'b1);
    @(negedge CLK);
    #2 rst = 1'b1;
    #1;
    chk_state("t6.arst", 16'h0000, 4'd0, 1'b0);
    chk("t6.dup", 32'(bus.dup_err), 32'd0);
    @(negedge CLK);
    rst = 1'b0;
    dig(2);
    chk_state("t6.entry", 16'h2000, 4'd1, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
